detect_winner_seq: RTL

Parametrised, sequential successor to the combinational tic-tac-toe win detector. It scans an N×N board one line per clock, covering N rows, N columns and 2 diagonals, and reports per-line wins, the winning player, draw and board-conflict status. A start/busy/done handshake lets the game controller launch a check after each move and collect a registered, stable result.

---
 rtl/detect_winner_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/detect_winner_seq.sv
// detect_winner_seq: sequential N x N tic-tac-toe win detector, one line evaluated per clock
// with start/busy/done handshake and registered results.
module detect_winner_seq #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*N-1:0]   ain,
    input  logic [N*N-1:0]   bin,
    output logic             busy,
    output logic             done,
    output logic [2*N+1:0]   win_line,
    output logic [1:0]       winner,
    output logic             draw,
    output logic             overlap
);
    localparam int L = 2*N + 2;
    localparam int C = N*N;
    localparam int IW = $clog2(L);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [C-1:0]   a_q, a_d, b_q, b_d;
    logic [L-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [L-1:0]   win_line_q, win_line_d;
    logic [1:0]     winner_q, winner_d;
    logic           draw_q, draw_d, overlap_q, overlap_d;
    logic [L-1:0]   a_all, b_all, onehot;

    // Bit pattern of the cells forming line k (rows, columns, main diag, anti-diag).
    function automatic logic [C-1:0] line_mask(input int k);
        line_mask = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if ((k < N && r == k) || (k >= N && k < 2*N && c == k - N) ||
                    (k == 2*N && r == c) || (k == 2*N + 1 && r + c == N - 1))
                    line_mask[C-1-(r*N+c)] = 1'b1;
    endfunction

    for (genvar k = 0; k < L; k++) begin : g_line
        assign a_all[k] = &(a_q | ~line_mask(k));
        assign b_all[k] = &(b_q | ~line_mask(k));
    end

    assign onehot = L'(1) << idx_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        win_line_d = win_line_q;
        winner_d   = winner_q;
        draw_d     = draw_q;
        overlap_d  = overlap_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                a_d     = ain;
                b_d     = bin;
                idx_d   = '0;
                acc_a_d = '0;
                acc_b_d = '0;
            end
            SCAN: begin
                acc_a_d = acc_a_q | (a_all & onehot);
                acc_b_d = acc_b_q | (b_all & onehot);
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(L-1)) begin
                    state_d    = DONE;
                    idx_d      = '0;
                    win_line_d = acc_a_d | acc_b_d;
                    winner_d   = {|acc_b_d, |acc_a_d};
                    draw_d     = &(a_q | b_q) && !(|acc_a_d) && !(|acc_b_d);
                    overlap_d  = |(a_q & b_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            win_line_q <= '0;
            winner_q   <= '0;
            draw_q     <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            win_line_q <= win_line_d;
            winner_q   <= winner_d;
            draw_q     <= draw_d;
            overlap_q  <= overlap_d;
        end
    end

    assign busy     = (state_q == SCAN);
    assign done     = (state_q == DONE);
    assign win_line = win_line_q;
    assign winner   = winner_q;
    assign draw     = draw_q;
    assign overlap  = overlap_q;
endmodule
